// File: rtl/cordic_share_arb_if.sv
// Requester, CORDIC-core and response signals shared by the arbiter and its neighbours.
interface cordic_share_arb_if #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned WL      = 18,
   parameter int unsigned PH_W    = 9
);
   localparam int unsigned ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ*WL-1:0] req_x;
   logic [NUM_REQ*WL-1:0] req_y;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ-1:0]    req_mask;
   logic                  cor_en;
   logic [WL-1:0]         cor_x;
   logic [WL-1:0]         cor_y;
   logic [WL-1:0]         cor_mag;
   logic [PH_W-1:0]       cor_phase;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [ID_W-1:0]       rsp_id;
   logic [WL-1:0]         rsp_mag;
   logic [PH_W-1:0]       rsp_phase;
   logic                  busy;

   modport slave (
      input  req_valid, req_x, req_y, req_mask, cor_mag, cor_phase, rsp_ready,
      output req_ready, cor_en, cor_x, cor_y, rsp_valid, rsp_id, rsp_mag, rsp_phase, busy
   );

   modport master (
      output req_valid, req_x, req_y, req_mask, cor_mag, cor_phase, rsp_ready,
      input  req_ready, cor_en, cor_x, cor_y, rsp_valid, rsp_id, rsp_mag, rsp_phase, busy
   );
endinterface

// File: rtl/cordic_share_arb.sv
// Round-robin front end sharing one pipelined CORDIC vectoring core among several
// requesters; results return in issue order through a credit-guarded FIFO.
module cordic_share_arb #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned WL         = 18,
   parameter int unsigned PH_W       = 9,
   parameter int unsigned CORDIC_LAT = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   cordic_share_arb_if.slave bus
);
   localparam int unsigned ID_W = $clog2(NUM_REQ);
   localparam int unsigned AW   = $clog2(FIFO_DEPTH);
   localparam int unsigned CW   = $clog2(FIFO_DEPTH + 1);

   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("cordic_share_arb: NUM_REQ must be 2..8");
   end
   if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FIFO_DEPTH < CORDIC_LAT + 1) begin : g_bad_depth
      $error("cordic_share_arb: FIFO_DEPTH must be a power of 2 and exceed CORDIC_LAT");
   end
   if (CORDIC_LAT < 1) begin : g_bad_lat
      $error("cordic_share_arb: CORDIC_LAT must be at least 1");
   end

   logic [ID_W-1:0]       ptr_q;
   logic [CW-1:0]         credit_q;
   logic                  cor_en_q;
   logic [ID_W-1:0]       iss_id_q;
   logic [WL-1:0]         cor_x_q;
   logic [WL-1:0]         cor_y_q;
   logic [CORDIC_LAT-1:0] tag_v_q;
   logic [ID_W-1:0]       tag_id_q  [CORDIC_LAT];
   logic [ID_W-1:0]       mem_id_q  [FIFO_DEPTH];
   logic [WL-1:0]         mem_mag_q [FIFO_DEPTH];
   logic [PH_W-1:0]       mem_ph_q  [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr_q;
   logic [AW-1:0]         rd_ptr_q;
   logic [CW-1:0]         count_q;

   logic [NUM_REQ-1:0]    eligible;
   logic                  grant;
   logic [ID_W-1:0]       grant_id;
   logic [NUM_REQ-1:0]    grant_oh;
   logic [ID_W-1:0]       rr_idx;
   logic                  push;
   logic                  pop;
   logic                  fifo_ne;

   // Round-robin search from ptr+1; no credit means nothing may be granted.
   always_comb begin
      eligible = (rst_n && credit_q != '0) ? (bus.req_valid & bus.req_mask) : '0;
      grant    = 1'b0;
      grant_id = '0;
      rr_idx   = '0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         rr_idx = ID_W'((32'(ptr_q) + i) % NUM_REQ);
         if (!grant && eligible[rr_idx]) begin
            grant    = 1'b1;
            grant_id = rr_idx;
         end
      end
      grant_oh = grant ? (NUM_REQ'(1) << grant_id) : '0;
   end

   assign fifo_ne = (count_q != '0);
   assign pop     = fifo_ne & bus.rsp_ready;
   assign push    = tag_v_q[CORDIC_LAT-1];

   // Issue register feeding the core; idle cycles present zeros.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q    <= ID_W'(NUM_REQ - 1);
         cor_en_q <= 1'b0;
         iss_id_q <= '0;
         cor_x_q  <= '0;
         cor_y_q  <= '0;
      end else begin
         if (grant) ptr_q <= grant_id;
         cor_en_q <= grant;
         iss_id_q <= grant_id;
         cor_x_q  <= grant ? bus.req_x[grant_id*WL +: WL] : '0;
         cor_y_q  <= grant ? bus.req_y[grant_id*WL +: WL] : '0;
      end
   end

   // Tags trail the issue register so the tail is valid in the cycle cor_mag is.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_v_q <= '0;
         for (int i = 0; i < CORDIC_LAT; i++) tag_id_q[i] <= '0;
      end else begin
         tag_v_q[0]  <= cor_en_q;
         tag_id_q[0] <= iss_id_q;
         for (int i = 1; i < CORDIC_LAT; i++) begin
            tag_v_q[i]  <= tag_v_q[i-1];
            tag_id_q[i] <= tag_id_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_id_q[i]  <= '0;
            mem_mag_q[i] <= '0;
            mem_ph_q[i]  <= '0;
         end
      end else begin
         if (push) begin
            mem_id_q[wr_ptr_q]  <= tag_id_q[CORDIC_LAT-1];
            mem_mag_q[wr_ptr_q] <= bus.cor_mag;
            mem_ph_q[wr_ptr_q]  <= bus.cor_phase;
            wr_ptr_q            <= wr_ptr_q + AW'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // A credit is reserved at grant and returned only when its result leaves the FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credit_q <= CW'(FIFO_DEPTH);
      end else begin
         case ({grant, pop})
            2'b10:   credit_q <= credit_q - CW'(1);
            2'b01:   credit_q <= credit_q + CW'(1);
            default: credit_q <= credit_q;
         endcase
      end
   end

   assign bus.req_ready = grant_oh;
   assign bus.cor_en    = cor_en_q;
   assign bus.cor_x     = cor_x_q;
   assign bus.cor_y     = cor_y_q;
   assign bus.rsp_valid = fifo_ne;
   assign bus.rsp_id    = mem_id_q[rd_ptr_q];
   assign bus.rsp_mag   = mem_mag_q[rd_ptr_q];
   assign bus.rsp_phase = mem_ph_q[rd_ptr_q];
   assign bus.busy      = cor_en_q | (|tag_v_q) | fifo_ne;

   credit_balance: assert property (@(posedge clk) disable iff (!rst_n)
      32'(credit_q) + 32'(cor_en_q) + 32'($countones(tag_v_q)) + 32'(count_q) == FIFO_DEPTH);

endmodule

// File: tb/tb_cordic_share_arb.sv
// Directed bench for cordic_share_arb with a stand-in one-stage core (mag=x+y, phase=(x>>2)^y).
module tb_cordic_share_arb;
   logic clk = 1'b0;
   logic rst_n;
   int   n_chk = 0;
   int   n_err = 0;

   typedef struct packed {
      logic [1:0]  id;
      logic [17:0] mag;
      logic [8:0]  ph;
   } exp_t;

   exp_t exp_q [$];

   logic [17:0] x_tab   [4] = '{18'h00200, 18'h00300, 18'h00400, 18'h10000};
   logic [17:0] y_tab   [4] = '{18'h00010, 18'h3FF00, 18'h00000, 18'h00123};
   logic [17:0] mag_tab [4] = '{18'h00210, 18'h00200, 18'h00400, 18'h10123};
   logic [8:0]  ph_tab  [4] = '{9'h090, 9'h1C0, 9'h100, 9'h123};

   cordic_share_arb_if #(.NUM_REQ(4), .WL(18), .PH_W(9)) bus ();

   cordic_share_arb #(
      .NUM_REQ(4), .WL(18), .PH_W(9), .CORDIC_LAT(1), .FIFO_DEPTH(4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [17:0] mag_r;
   logic [8:0]  ph_r;
   always @(posedge clk) begin
      if (bus.cor_en) begin
         mag_r <= bus.cor_x + bus.cor_y;
         ph_r  <= 9'(bus.cor_x >> 2) ^ bus.cor_y[8:0];
      end else begin
         mag_r <= 18'h2AAAA;
         ph_r  <= 9'h155;
      end
   end
   assign bus.cor_mag   = mag_r;
   assign bus.cor_phase = ph_r;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Every accepted response is checked against the head of the expected queue.
   always @(negedge clk) begin
      if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
         if (exp_q.size() == 0) begin
            chk("rsp_unexpected", 32'(bus.rsp_id), 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rsp_id",    32'(bus.rsp_id),    32'(e.id));
            chk("rsp_mag",   32'(bus.rsp_mag),   32'(e.mag));
            chk("rsp_phase", 32'(bus.rsp_phase), 32'(e.ph));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input int k);
      exp_q.push_back('{id: 2'(k), mag: mag_tab[k], ph: ph_tab[k]});
   endtask

   task automatic grant_cycle(input string tag, input logic [3:0] oh, input int k);
      #1;
      chk(tag, 32'(bus.req_ready), 32'(oh));
      if (oh != 4'b0) push_exp(k);
      tick();
   endtask

   task automatic pulse_reset();
      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.rsp_ready = 1'b0;
      exp_q.delete();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic drain(input string tag);
      int n;
      n             = 0;
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      while ((exp_q.size() != 0 || bus.busy) && n < 40) begin
         tick();
         n++;
      end
      chk({tag, "_left"},  32'(exp_q.size()), 32'd0);
      chk({tag, "_busy"},  32'(bus.busy),     32'd0);
      chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'd0);
      bus.rsp_ready = 1'b0;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] oh;
      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.req_mask  = 4'hF;
      bus.rsp_ready = 1'b0;
      bus.req_x     = {x_tab[3], x_tab[2], x_tab[1], x_tab[0]};
      bus.req_y     = {y_tab[3], y_tab[2], y_tab[1], y_tab[0]};
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_cor_en",    32'(bus.cor_en),    32'd0);
      chk("rst_cor_x",     32'(bus.cor_x),     32'd0);
      chk("rst_cor_y",     32'(bus.cor_y),     32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_id",    32'(bus.rsp_id),    32'd0);
      chk("rst_rsp_mag",   32'(bus.rsp_mag),   32'd0);
      chk("rst_rsp_phase", 32'(bus.rsp_phase), 32'd0);
      chk("rst_busy",      32'(bus.busy),      32'd0);
      rst_n = 1'b1;
      tick();

      // Single requester 2, latency and result path
      bus.req_valid = 4'b0100;
      #1;
      chk("t1_grant", 32'(bus.req_ready), 32'h4);
      push_exp(2);
      tick();
      bus.req_valid = '0;
      chk("t1_cor_en",   32'(bus.cor_en),    32'd1);
      chk("t1_cor_x",    32'(bus.cor_x),     32'h00400);
      chk("t1_cor_y",    32'(bus.cor_y),     32'd0);
      chk("t1_busy",     32'(bus.busy),      32'd1);
      chk("t1_valid_c1", 32'(bus.rsp_valid), 32'd0);
      tick();
      chk("t1_cor_en_c2", 32'(bus.cor_en),    32'd0);
      chk("t1_valid_c2",  32'(bus.rsp_valid), 32'd0);
      tick();
      chk("t1_valid_c3", 32'(bus.rsp_valid), 32'd1);
      chk("t1_id",       32'(bus.rsp_id),    32'd2);
      chk("t1_mag",      32'(bus.rsp_mag),   32'h00400);
      chk("t1_phase",    32'(bus.rsp_phase), 32'h100);
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      chk("t1_popped", 32'(bus.rsp_valid), 32'd0);
      chk("t1_idle",   32'(bus.busy),      32'd0);

      // Round robin, all requesters valid, downstream always ready
      pulse_reset();
      bus.rsp_ready = 1'b1;
      bus.req_valid = 4'hF;
      for (int i = 0; i < 8; i++) begin
         oh = 4'b0001 << (i % 4);
         grant_cycle("rr_grant", oh, i % 4);
      end
      drain("rr_drain");

      // Backpressure: four credits, then one more per pop
      pulse_reset();
      bus.req_valid = 4'hF;
      grant_cycle("bp_g0", 4'h1, 0);
      grant_cycle("bp_g1", 4'h2, 1);
      grant_cycle("bp_g2", 4'h4, 2);
      grant_cycle("bp_g3", 4'h8, 3);
      for (int i = 0; i < 3; i++) grant_cycle("bp_stall", 4'h0, 0);
      chk("bp_full_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_head_id",    32'(bus.rsp_id),    32'd0);
      bus.rsp_ready = 1'b1;
      #1;
      chk("bp_pop_nogrant", 32'(bus.req_ready), 32'd0);
      tick();
      bus.rsp_ready = 1'b0;
      grant_cycle("bp_refill", 4'h1, 0);
      grant_cycle("bp_hold1", 4'h0, 0);
      grant_cycle("bp_hold2", 4'h0, 0);
      drain("bp_drain");

      // Mask 1010: only 1 and 3, alternating
      pulse_reset();
      bus.req_mask  = 4'b1010;
      bus.rsp_ready = 1'b1;
      bus.req_valid = 4'hF;
      for (int i = 0; i < 3; i++) begin
         grant_cycle("mask_g1", 4'h2, 1);
         grant_cycle("mask_g3", 4'h8, 3);
      end
      drain("mask_drain");
      bus.req_mask = 4'hF;

      // Grant coinciding with pop at credit 1
      pulse_reset();
      bus.req_valid = 4'hF;
      grant_cycle("cr1_g0", 4'h1, 0);
      grant_cycle("cr1_g1", 4'h2, 1);
      grant_cycle("cr1_g2", 4'h4, 2);
      bus.req_valid = '0;
      repeat (3) tick();
      chk("cr1_queued", 32'(bus.rsp_valid), 32'd1);
      bus.req_valid = 4'b1000;
      bus.rsp_ready = 1'b1;
      grant_cycle("cr1_grant_pop", 4'h8, 3);
      bus.rsp_ready = 1'b0;
      bus.req_valid = 4'hF;
      grant_cycle("cr1_kept", 4'h1, 0);
      grant_cycle("cr1_empty", 4'h0, 0);
      drain("cr1_drain");

      // Reset with three queued and one in flight
      pulse_reset();
      bus.req_valid = 4'hF;
      grant_cycle("rs_g0", 4'h1, 0);
      grant_cycle("rs_g1", 4'h2, 1);
      grant_cycle("rs_g2", 4'h4, 2);
      grant_cycle("rs_g3", 4'h8, 3);
      grant_cycle("rs_stall", 4'h0, 0);
      chk("rs_pre_valid", 32'(bus.rsp_valid), 32'd1);
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("rs_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rs_busy",      32'(bus.busy),      32'd0);
      chk("rs_cor_en",    32'(bus.cor_en),    32'd0);
      chk("rs_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rs_rsp_id",    32'(bus.rsp_id),    32'd0);
      tick();
      rst_n = 1'b1;
      grant_cycle("rs_after_g0", 4'h1, 0);
      grant_cycle("rs_after_g1", 4'h2, 1);
      grant_cycle("rs_after_g2", 4'h4, 2);
      grant_cycle("rs_after_g3", 4'h8, 3);
      grant_cycle("rs_after_stall", 4'h0, 0);
      drain("rs_drain");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/cordic_share_arb.md
Name: cordic_share_arb

Overview:
- Shares one pipelined CORDIC vectoring core (Q8.10, 18-bit) among NUM_REQ symbol requesters in the APSK demapper front end.
- Arbitrates round-robin, issues at most one sample per cycle, and tags each issue with its requester ID.
- Captures results CORDIC_LAT cycles after issue into an output FIFO and returns them with the ID.
- Credit control ensures no result is ever dropped.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- WL, 18: sample and magnitude word length (Q8.10).
- PH_W, 9: phase-decision bits from the CORDIC ({angle_pre, pre_rot, angle_0..angle_6}).
- CORDIC_LAT, 1: cycles from the cor_en issue edge to the result being valid on cor_mag/cor_phase.
- FIFO_DEPTH, 4: result FIFO entries (power of 2, ≥ CORDIC_LAT+1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester sample valid
- req_x  in  NUM_REQ*WL  flattened I samples; requester k at [k*WL +: WL]
- req_y  in  NUM_REQ*WL  flattened Q samples
- req_ready  out  NUM_REQ  one-hot grant; handshake completes on valid&ready
- req_mask  in  NUM_REQ  1 = requester enabled; masked requesters are never granted
- cor_en  out  1  issue strobe to the CORDIC
- cor_x  out  WL  issued I sample
- cor_y  out  WL  issued Q sample
- cor_mag  in  WL  CORDIC magnitude result
- cor_phase  in  PH_W  CORDIC phase-decision bits
- rsp_valid  out  1  FIFO head valid
- rsp_ready  in  1  downstream accept
- rsp_id  out  clog2(NUM_REQ)  requester ID of the head entry
- rsp_mag  out  WL  head magnitude
- rsp_phase  out  PH_W  head phase bits
- busy  out  1  one or more samples in flight or FIFO not empty

Behaviour:
- Reset values:
  - req_ready=0, cor_en=0, cor_x=cor_y=0.
  - rsp_valid=0; rsp_id/rsp_mag/rsp_phase=0.
  - busy=0, RR pointer=NUM_REQ-1, credit=FIFO_DEPTH, tag pipeline cleared, FIFO empty.
- Eligibility: eligible = req_valid & req_mask, and credit>0.
- Round-robin arbitration:
  - Search starts at (ptr+1) mod NUM_REQ; the first eligible requester k is granted.
  - The grant is combinational: req_ready[k]=1 in the same cycle.
  - On a grant, ptr←k. With no grant, ptr holds.
  - req_ready is all zero when no requester is eligible.
- Issue registers (1 cycle):
  - On grant, cor_en←1, cor_x←req_x[k], cor_y←req_y[k] at the next edge.
  - Otherwise cor_en←0 and cor_x/cor_y←0.
- Tag pipeline:
  - Shift register of depth CORDIC_LAT carrying {valid, id}.
  - Entry is loaded with {1,k} on the same edge as cor_en.
  - When the tail valid=1, {id, cor_mag, cor_phase} is written into the FIFO on that edge.
- FIFO:
  - Pop on rsp_valid&rsp_ready.
  - rsp_* shows the head combinationally from registered storage.
  - Read/write pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop when non-empty: occupancy unchanged.
  - Push into an empty FIFO: rsp_valid rises the following cycle.
- Credit counter (range 0..FIFO_DEPTH):
  - −1 on grant, +1 on pop; a simultaneous grant and pop leaves it unchanged.
  - Invariant: credit + in-flight + occupancy = FIFO_DEPTH, so a FIFO overflow cannot occur.
  - When credit=0, all req_ready=0 until a pop.
- busy = any tag valid | FIFO non-empty | cor_en.
- Masking:
  - Changing req_mask mid-stream affects only future grants; in-flight and queued results still drain.
- Reset mid-operation:
  - All in-flight tags and FIFO contents are discarded, and every output returns to its reset value.
  - Results arriving on cor_mag after reset are ignored, because all tags are invalid.
- Latency: handshake to rsp_valid = CORDIC_LAT+2 cycles when the FIFO is empty.
- Ordering: results leave in issue order; the ID identifies the owner.

Test Plan:
- Single requester: req_valid[2]=1 for one cycle with x=0x00400 (1.0), y=0. Required: req_ready=4'b0100; cor_en one cycle later with cor_x=0x00400; rsp_valid CORDIC_LAT+2 cycles after the handshake with rsp_id=2 and the model's rsp_mag/rsp_phase.
- Round robin: all four requesters held valid, rsp_ready=1. Required: grant order 0,1,2,3,0,…; one issue per cycle; credit never reaches 0; the rsp_id sequence matches.
- Backpressure: rsp_ready=0, all requesters valid. Required: exactly FIFO_DEPTH=4 grants, then req_ready=0. After one rsp_ready pulse, exactly one further grant. No entry is lost or duplicated.
- Mask: req_mask=4'b1010 with all requesters valid. Required: only IDs 1 and 3 are granted, alternating.
- Simultaneous pop and grant at credit=1: one pop coincides with one grant. Required: credit stays 1; FIFO occupancy is unchanged when a push coincides with that pop.
- Reset mid-stream: assert rst_n=0 with 3 entries queued and 1 in flight. Required: immediately rsp_valid=0, busy=0, cor_en=0. After release, credit=4 and the next grant goes to requester 0.
